// File: rtl/cpu_ctrl_pkg.sv
// Shared opcodes, FSM states, opcode classes and strobe bundle for the Mini-SRC control unit.
package cpu_ctrl_pkg;

  localparam int unsigned OPW = 5;
  localparam int unsigned IRW = 32;

  localparam logic [OPW-1:0] OPC_LD   = 5'b00000;
  localparam logic [OPW-1:0] OPC_LDI  = 5'b00001;
  localparam logic [OPW-1:0] OPC_ST   = 5'b00010;
  localparam logic [OPW-1:0] OPC_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OPC_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OPC_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OPC_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OPC_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OPC_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OPC_AND  = 5'b01001;
  localparam logic [OPW-1:0] OPC_OR   = 5'b01010;
  localparam logic [OPW-1:0] OPC_ADDI = 5'b01011;
  localparam logic [OPW-1:0] OPC_ANDI = 5'b01100;
  localparam logic [OPW-1:0] OPC_ORI  = 5'b01101;
  localparam logic [OPW-1:0] OPC_MUL  = 5'b01110;
  localparam logic [OPW-1:0] OPC_DIV  = 5'b01111;
  localparam logic [OPW-1:0] OPC_NEG  = 5'b10000;
  localparam logic [OPW-1:0] OPC_NOT  = 5'b10001;
  localparam logic [OPW-1:0] OPC_BR   = 5'b10010;
  localparam logic [OPW-1:0] OPC_JR   = 5'b10011;
  localparam logic [OPW-1:0] OPC_IN   = 5'b10101;
  localparam logic [OPW-1:0] OPC_OUT  = 5'b10110;
  localparam logic [OPW-1:0] OPC_MFHI = 5'b10111;
  localparam logic [OPW-1:0] OPC_MFLO = 5'b11000;
  localparam logic [OPW-1:0] OPC_NOP  = 5'b11001;
  localparam logic [OPW-1:0] OPC_HALT = 5'b11010;

  // ALU code used for PC increment, address and branch-offset arithmetic
  localparam logic [OPW-1:0] OP_ADD = OPC_ADD;

  typedef enum logic [3:0] {
    S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  // Opcode classes that share one execute sequence
  typedef enum logic [3:0] {
    K_NOP, K_ALU3, K_ALU2, K_IMM, K_MULDIV, K_LD, K_LDI, K_ST,
    K_BR, K_JR, K_IN, K_OUT, K_MFHI, K_MFLO, K_HALT
  } kind_t;

  typedef struct packed {
    logic PCout;     logic MDRout;     logic ZLowout;    logic ZHighout;
    logic HIout;     logic LOout;      logic InPortout;  logic Cout;
    logic BAout;     logic R_out;      logic PC_enable;  logic IR_enable;
    logic MAR_enable; logic MDR_enable; logic Y_enable;  logic ZLowIn;
    logic ZHighIn;   logic HI_enable;  logic LO_enable;  logic R_in;
    logic OutPort_enable; logic CON_enable; logic MDR_read; logic RAM_write;
    logic IncPC;     logic Gra;        logic Grb;        logic Grc;
  } ctrl_t;

  // Map an opcode onto its execute-sequence class; unknown opcodes behave as nop
  function automatic kind_t op_kind(input logic [OPW-1:0] op);
    case (op)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR,
      OPC_SHR, OPC_SHL, OPC_ROR, OPC_ROL: op_kind = K_ALU3;
      OPC_NEG, OPC_NOT:                   op_kind = K_ALU2;
      OPC_ADDI, OPC_ANDI, OPC_ORI:        op_kind = K_IMM;
      OPC_MUL, OPC_DIV:                   op_kind = K_MULDIV;
      OPC_LD:                             op_kind = K_LD;
      OPC_LDI:                            op_kind = K_LDI;
      OPC_ST:                             op_kind = K_ST;
      OPC_BR:                             op_kind = K_BR;
      OPC_JR:                             op_kind = K_JR;
      OPC_IN:                             op_kind = K_IN;
      OPC_OUT:                            op_kind = K_OUT;
      OPC_MFHI:                           op_kind = K_MFHI;
      OPC_MFLO:                           op_kind = K_MFLO;
      OPC_HALT:                           op_kind = K_HALT;
      default:                            op_kind = K_NOP;
    endcase
  endfunction

  // Final execute state for each class; the FSM leaves it for T0 or HALT
  function automatic state_t last_state(input kind_t k);
    case (k)
      K_ALU3, K_ALU2, K_IMM, K_LDI: last_state = S_T5;
      K_MULDIV, K_BR:               last_state = S_T6;
      K_LD, K_ST:                   last_state = S_T7;
      default:                      last_state = S_T3;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Moore output decode: current state plus opcode class to datapath strobes and ALU code.
module ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  state_t         state,
  input  logic [OPW-1:0] opcode,
  input  logic           con_ff,
  output ctrl_t          ctrl,
  output logic [OPW-1:0] alu_op,
  output logic           run
);

  kind_t kind;
  assign kind = op_kind(opcode);

  // Strobes for one state; everything defaults low, so RESET/HALT assert nothing
  always_comb begin
    ctrl   = '0;
    alu_op = '0;
    run    = (state != S_HALT);
    case (state)
      S_T0: begin
        ctrl.PCout = 1'b1; ctrl.MAR_enable = 1'b1; ctrl.IncPC = 1'b1; ctrl.ZLowIn = 1'b1;
        alu_op = OP_ADD;
      end
      S_T1: begin
        ctrl.ZLowout = 1'b1; ctrl.PC_enable = 1'b1; ctrl.MDR_read = 1'b1; ctrl.MDR_enable = 1'b1;
      end
      S_T2: begin
        ctrl.MDRout = 1'b1; ctrl.IR_enable = 1'b1;
      end
      S_T3: begin
        case (kind)
          K_ALU3, K_ALU2, K_IMM: begin ctrl.Grb = 1'b1; ctrl.R_out = 1'b1; ctrl.Y_enable = 1'b1; end
          K_MULDIV:              begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.Y_enable = 1'b1; end
          K_LD, K_LDI, K_ST:     begin ctrl.Grb = 1'b1; ctrl.BAout = 1'b1; ctrl.Y_enable = 1'b1; end
          K_BR:   begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.CON_enable = 1'b1; end
          K_JR:   begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.PC_enable = 1'b1; end
          K_IN:   begin ctrl.InPortout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
          K_OUT:  begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.OutPort_enable = 1'b1; end
          K_MFHI: begin ctrl.HIout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
          K_MFLO: begin ctrl.LOout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (kind)
          K_ALU3: begin ctrl.Grc = 1'b1; ctrl.R_out = 1'b1; ctrl.ZLowIn = 1'b1; alu_op = opcode; end
          K_ALU2: begin ctrl.Grb = 1'b1; ctrl.R_out = 1'b1; ctrl.ZLowIn = 1'b1; alu_op = opcode; end
          K_IMM:  begin ctrl.Cout = 1'b1; ctrl.ZLowIn = 1'b1; alu_op = opcode; end
          K_MULDIV: begin
            ctrl.Grb = 1'b1; ctrl.R_out = 1'b1; ctrl.ZLowIn = 1'b1; ctrl.ZHighIn = 1'b1;
            alu_op = opcode;
          end
          K_LD, K_LDI, K_ST: begin ctrl.Cout = 1'b1; ctrl.ZLowIn = 1'b1; alu_op = OP_ADD; end
          K_BR:   begin ctrl.PCout = 1'b1; ctrl.Y_enable = 1'b1; end
          default: ;
        endcase
      end
      S_T5: begin
        case (kind)
          K_ALU3, K_ALU2, K_IMM, K_LDI: begin ctrl.ZLowout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
          K_MULDIV:   begin ctrl.ZLowout = 1'b1; ctrl.LO_enable = 1'b1; end
          K_LD, K_ST: begin ctrl.ZLowout = 1'b1; ctrl.MAR_enable = 1'b1; end
          K_BR:       begin ctrl.Cout = 1'b1; ctrl.ZLowIn = 1'b1; alu_op = OP_ADD; end
          default: ;
        endcase
      end
      S_T6: begin
        case (kind)
          K_MULDIV: begin ctrl.ZHighout = 1'b1; ctrl.HI_enable = 1'b1; end
          K_LD:     begin ctrl.MDR_read = 1'b1; ctrl.MDR_enable = 1'b1; end
          K_ST:     begin ctrl.Gra = 1'b1; ctrl.R_out = 1'b1; ctrl.MDR_enable = 1'b1; end
          K_BR:     begin ctrl.ZLowout = 1'b1; ctrl.PC_enable = con_ff; end
          default: ;
        endcase
      end
      S_T7: begin
        case (kind)
          K_LD: begin ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.R_in = 1'b1; end
          K_ST: ctrl.RAM_write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Mini-SRC control unit: fetch/execute sequencer with Stop/halt handling.
module control_unit
  import cpu_ctrl_pkg::*;
(
  input  logic        Clock,
  input  logic        Clear,
  input  logic        Stop,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        Run,
  output logic        PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout, R_out,
  output logic        PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn,
  output logic        HI_enable, LO_enable, R_in, OutPort_enable, CON_enable,
  output logic        MDR_read, RAM_write, IncPC,
  output logic        Gra, Grb, Grc,
  output logic [4:0]  ALU_op
);

  state_t         state;
  ctrl_t          ctrl;
  logic [OPW-1:0] opcode;
  kind_t          kind;
  logic           unused_ir;

  assign opcode    = IR[IRW-1 -: OPW];
  assign kind      = op_kind(opcode);
  assign unused_ir = ^IR[IRW-OPW-1:0];

  // State register with next-state logic; Clear wins from any state
  always_ff @(posedge Clock) begin
    if (Clear) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_T0;
        S_T0:    state <= S_T1;
        S_T1:    state <= S_T2;
        S_T2:    state <= S_T3;
        S_HALT:  state <= S_HALT;
        default: begin
          if (state == S_T3 && kind == K_HALT)
            state <= S_HALT;
          else if (state == last_state(kind))
            state <= Stop ? S_HALT : S_T0;
          else
            state <= state_t'(4'(state) + 4'd1);
        end
      endcase
    end
  end

  ctrl_decode u_decode (
    .state  (state),
    .opcode (opcode),
    .con_ff (CON_FF),
    .ctrl   (ctrl),
    .alu_op (ALU_op),
    .run    (Run)
  );

  assign PCout          = ctrl.PCout;
  assign MDRout         = ctrl.MDRout;
  assign ZLowout        = ctrl.ZLowout;
  assign ZHighout       = ctrl.ZHighout;
  assign HIout          = ctrl.HIout;
  assign LOout          = ctrl.LOout;
  assign InPortout      = ctrl.InPortout;
  assign Cout           = ctrl.Cout;
  assign BAout          = ctrl.BAout;
  assign R_out          = ctrl.R_out;
  assign PC_enable      = ctrl.PC_enable;
  assign IR_enable      = ctrl.IR_enable;
  assign MAR_enable     = ctrl.MAR_enable;
  assign MDR_enable     = ctrl.MDR_enable;
  assign Y_enable       = ctrl.Y_enable;
  assign ZLowIn         = ctrl.ZLowIn;
  assign ZHighIn        = ctrl.ZHighIn;
  assign HI_enable      = ctrl.HI_enable;
  assign LO_enable      = ctrl.LO_enable;
  assign R_in           = ctrl.R_in;
  assign OutPort_enable = ctrl.OutPort_enable;
  assign CON_enable     = ctrl.CON_enable;
  assign MDR_read       = ctrl.MDR_read;
  assign RAM_write      = ctrl.RAM_write;
  assign IncPC          = ctrl.IncPC;
  assign Gra            = ctrl.Gra;
  assign Grb            = ctrl.Grb;
  assign Grc            = ctrl.Grc;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: per-cycle table of inputs and expected strobes.
module tb_control_unit;

  logic Clock = 1'b0;
  logic Clear, Stop, CON_FF;
  logic [31:0] IR;
  logic Run;
  logic PCout, MDRout, ZLowout, ZHighout, HIout, LOout, InPortout, Cout, BAout, R_out;
  logic PC_enable, IR_enable, MAR_enable, MDR_enable, Y_enable, ZLowIn, ZHighIn;
  logic HI_enable, LO_enable, R_in, OutPort_enable, CON_enable;
  logic MDR_read, RAM_write, IncPC, Gra, Grb, Grc;
  logic [4:0] ALU_op;

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .Stop(Stop), .IR(IR), .CON_FF(CON_FF), .Run(Run),
    .PCout(PCout), .MDRout(MDRout), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIout(HIout),
    .LOout(LOout), .InPortout(InPortout), .Cout(Cout), .BAout(BAout), .R_out(R_out),
    .PC_enable(PC_enable), .IR_enable(IR_enable), .MAR_enable(MAR_enable),
    .MDR_enable(MDR_enable), .Y_enable(Y_enable), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
    .HI_enable(HI_enable), .LO_enable(LO_enable), .R_in(R_in), .OutPort_enable(OutPort_enable),
    .CON_enable(CON_enable), .MDR_read(MDR_read), .RAM_write(RAM_write), .IncPC(IncPC),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .ALU_op(ALU_op)
  );

  // Strobe bit positions in the observed vector
  localparam logic [27:0] PCO  = 28'd1 << 0,  MDRO = 28'd1 << 1,  ZLO  = 28'd1 << 2;
  localparam logic [27:0] ZHO  = 28'd1 << 3,  HIO  = 28'd1 << 4,  LOO  = 28'd1 << 5;
  localparam logic [27:0] INPO = 28'd1 << 6,  CO   = 28'd1 << 7,  BAO  = 28'd1 << 8;
  localparam logic [27:0] RO   = 28'd1 << 9,  PCE  = 28'd1 << 10, IRE  = 28'd1 << 11;
  localparam logic [27:0] MARE = 28'd1 << 12, MDRE = 28'd1 << 13, YE   = 28'd1 << 14;
  localparam logic [27:0] ZLI  = 28'd1 << 15, ZHI  = 28'd1 << 16, HIE  = 28'd1 << 17;
  localparam logic [27:0] LOE  = 28'd1 << 18, RIN  = 28'd1 << 19, OPE  = 28'd1 << 20;
  localparam logic [27:0] CONE = 28'd1 << 21, MDRR = 28'd1 << 22, RAMW = 28'd1 << 23;
  localparam logic [27:0] INC  = 28'd1 << 24, GRA  = 28'd1 << 25, GRB  = 28'd1 << 26;
  localparam logic [27:0] GRC  = 28'd1 << 27;
  localparam logic [27:0] NONE = 28'd0;

  localparam logic [4:0] A0 = 5'b00000, AADD = 5'b00011;

  logic [27:0] obs;
  assign obs = {Grc, Grb, Gra, IncPC, RAM_write, MDR_read, CON_enable, OutPort_enable, R_in,
                LO_enable, HI_enable, ZHighIn, ZLowIn, Y_enable, MDR_enable, MAR_enable,
                IR_enable, PC_enable, R_out, BAout, Cout, InPortout, LOout, HIout, ZHighout,
                ZLowout, MDRout, PCout};

  typedef struct {
    bit          clr;
    bit          stp;
    bit          con;
    logic [31:0] ir;
    logic [27:0] strb;
    logic [4:0]  alu;
    bit          run;
  } vec_t;

  vec_t tv[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra,
                                     input logic [3:0] rb, input logic [18:0] c);
    return {op, ra, rb, c};
  endfunction

  task automatic add(input bit clr, input bit stp, input bit con, input logic [31:0] ir,
                     input logic [27:0] s, input logic [4:0] a, input bit r);
    tv.push_back('{clr, stp, con, ir, s, a, r});
  endtask

  // T0..T2 fetch cycles, identical for every instruction
  task automatic fetch(input logic [31:0] ir, input bit con);
    add(0, 0, con, ir, PCO | MARE | INC | ZLI, AADD, 1);
    add(0, 0, con, ir, ZLO | PCE | MDRR | MDRE, A0, 1);
    add(0, 0, con, ir, MDRO | IRE, A0, 1);
  endtask

  // Drive one cycle's inputs after the falling edge and check the Moore outputs
  task automatic step(input string tag, input int idx, input bit clr, input bit stp, input bit con,
                      input logic [31:0] ir, input logic [27:0] s, input logic [4:0] a,
                      input bit r);
    @(negedge Clock);
    Clear = clr; Stop = stp; CON_FF = con; IR = ir;
    #1;
    checks++;
    if (obs !== s) begin
      errors++;
      $display("FAIL %s[%0d] strobes got %h want %h", tag, idx, obs, s);
    end
    checks++;
    if (ALU_op !== a) begin
      errors++;
      $display("FAIL %s[%0d] ALU_op got %b want %b", tag, idx, ALU_op, a);
    end
    checks++;
    if (Run !== r) begin
      errors++;
      $display("FAIL %s[%0d] Run got %b want %b", tag, idx, Run, r);
    end
  endtask

  initial begin
    logic [31:0] i_addi, i_ld, i_st, i_br, i_neg, i_jr, i_in, i_out, i_mflo, i_nop, i_halt, i_mul;
    i_addi = mk(5'b01011, 4'd1, 4'd2, 19'd5);
    i_ld   = mk(5'b00000, 4'd3, 4'd0, 19'd8);
    i_st   = mk(5'b00010, 4'd5, 4'd2, 19'd4);
    i_br   = mk(5'b10010, 4'd1, 4'd0, 19'd3);
    i_neg  = mk(5'b10000, 4'd1, 4'd2, 19'd0);
    i_jr   = mk(5'b10011, 4'd6, 4'd0, 19'd0);
    i_in   = mk(5'b10101, 4'd2, 4'd0, 19'd0);
    i_out  = mk(5'b10110, 4'd2, 4'd0, 19'd0);
    i_mflo = mk(5'b11000, 4'd4, 4'd0, 19'd0);
    i_nop  = mk(5'b11001, 4'd0, 4'd0, 19'd0);
    i_halt = mk(5'b11010, 4'd0, 4'd0, 19'd0);
    i_mul  = mk(5'b01110, 4'd3, 4'd4, 19'd0);

    add(0, 0, 0, i_addi, NONE, A0, 1);                      // RESET
    fetch(i_addi, 0);                                       // addi: 6 cycles
    add(0, 0, 0, i_addi, GRB | RO | YE, A0, 1);
    add(0, 0, 0, i_addi, CO | ZLI, 5'b01011, 1);
    add(0, 0, 0, i_addi, ZLO | GRA | RIN, A0, 1);
    fetch(i_ld, 0);                                         // ld: 8 cycles
    add(0, 0, 0, i_ld, GRB | BAO | YE, A0, 1);
    add(0, 0, 0, i_ld, CO | ZLI, AADD, 1);
    add(0, 0, 0, i_ld, ZLO | MARE, A0, 1);
    add(0, 0, 0, i_ld, MDRR | MDRE, A0, 1);
    add(0, 0, 0, i_ld, MDRO | GRA | RIN, A0, 1);
    fetch(i_st, 0);                                         // st: 8 cycles
    add(0, 0, 0, i_st, GRB | BAO | YE, A0, 1);
    add(0, 0, 0, i_st, CO | ZLI, AADD, 1);
    add(0, 0, 0, i_st, ZLO | MARE, A0, 1);
    add(0, 0, 0, i_st, GRA | RO | MDRE, A0, 1);
    add(0, 0, 0, i_st, RAMW, A0, 1);
    for (int c = 0; c < 2; c++) begin                       // br, CON_FF=0 then 1
      fetch(i_br, c[0]);
      add(0, 0, c[0], i_br, GRA | RO | CONE, A0, 1);
      add(0, 0, c[0], i_br, PCO | YE, A0, 1);
      add(0, 0, c[0], i_br, CO | ZLI, AADD, 1);
      add(0, 0, c[0], i_br, (c == 1) ? (ZLO | PCE) : ZLO, A0, 1);
    end
    fetch(i_neg, 0);                                        // neg: Grb in T4
    add(0, 0, 0, i_neg, GRB | RO | YE, A0, 1);
    add(0, 0, 0, i_neg, GRB | RO | ZLI, 5'b10000, 1);
    add(0, 0, 0, i_neg, ZLO | GRA | RIN, A0, 1);
    fetch(i_jr, 0);   add(0, 0, 0, i_jr,   GRA | RO | PCE,   A0, 1);
    fetch(i_in, 0);   add(0, 0, 0, i_in,   INPO | GRA | RIN, A0, 1);
    fetch(i_out, 0);  add(0, 0, 0, i_out,  GRA | RO | OPE,   A0, 1);
    fetch(i_mflo, 0); add(0, 0, 0, i_mflo, LOO | GRA | RIN,  A0, 1);
    fetch(i_nop, 0);  add(0, 0, 0, i_nop,  NONE,             A0, 1);
    fetch(i_halt, 0); add(0, 0, 0, i_halt, NONE,             A0, 1);
    add(0, 0, 0, i_halt, NONE, A0, 0);                      // HALT
    add(1, 0, 0, i_halt, NONE, A0, 0);                      // HALT, Clear raised
    add(0, 0, 0, i_halt, NONE, A0, 1);                      // RESET

    Clear = 1'b1; Stop = 1'b0; CON_FF = 1'b0; IR = 32'd0;
    @(posedge Clock);

    foreach (tv[i])
      step("vec", i, tv[i].clr, tv[i].stp, tv[i].con, tv[i].ir, tv[i].strb, tv[i].alu, tv[i].run);

    // Clear in the middle of ld (T5) aborts the instruction
    step("ldclr", 0, 0, 0, 0, i_ld, PCO | MARE | INC | ZLI, AADD, 1);
    step("ldclr", 1, 0, 0, 0, i_ld, ZLO | PCE | MDRR | MDRE, A0, 1);
    step("ldclr", 2, 0, 0, 0, i_ld, MDRO | IRE, A0, 1);
    step("ldclr", 3, 0, 0, 0, i_ld, GRB | BAO | YE, A0, 1);
    step("ldclr", 4, 0, 0, 0, i_ld, CO | ZLI, AADD, 1);
    step("ldclr", 5, 1, 0, 0, i_ld, ZLO | MARE, A0, 1);
    step("ldclr", 6, 0, 0, 0, i_ld, NONE, A0, 1);

    // mul with Stop raised in T4: T5/T6 still run, then HALT
    step("mulstop", 0, 0, 0, 0, i_mul, PCO | MARE | INC | ZLI, AADD, 1);
    step("mulstop", 1, 0, 0, 0, i_mul, ZLO | PCE | MDRR | MDRE, A0, 1);
    step("mulstop", 2, 0, 0, 0, i_mul, MDRO | IRE, A0, 1);
    step("mulstop", 3, 0, 0, 0, i_mul, GRA | RO | YE, A0, 1);
    step("mulstop", 4, 0, 1, 0, i_mul, GRB | RO | ZLI | ZHI, 5'b01110, 1);
    step("mulstop", 5, 0, 1, 0, i_mul, ZLO | LOE, A0, 1);
    step("mulstop", 6, 0, 1, 0, i_mul, ZHO | HIE, A0, 1);
    for (int k = 0; k < 20; k++)
      step("halt", k, 0, k[0], 1, i_addi, NONE, A0, 0);
    step("halt", 20, 1, 0, 0, i_addi, NONE, A0, 0);
    step("rst", 0, 0, 0, 0, i_addi, NONE, A0, 1);
    step("rst", 1, 0, 0, 0, i_addi, PCO | MARE | INC | ZLI, AADD, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
